// File: rtl/inst_window_pkg.sv
// Shared types and RiSC-16 opcode constants for the instruction window and the core benches.
package inst_window_pkg;

    localparam int WORD_LEN = 16;

    typedef struct packed {
        logic [WORD_LEN-1:0] inst;
        logic [WORD_LEN-1:0] pc;
    } entry_t;

    localparam logic [2:0] ADD  = 3'd0;
    localparam logic [2:0] ADDI = 3'd1;
    localparam logic [2:0] NAND = 3'd2;
    localparam logic [2:0] LUI  = 3'd3;
    localparam logic [2:0] SW   = 3'd4;
    localparam logic [2:0] LW   = 3'd5;
    localparam logic [2:0] BEQ  = 3'd6;
    localparam logic [2:0] JALR = 3'd7;

endpackage

// File: rtl/inst_window_chk.sv
// Commit-time PC comparator with a sticky error flag and a saturating mismatch counter.
module inst_window_chk #(
    parameter int p_WORD_LEN = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_check,
    input  logic [p_WORD_LEN-1:0] i_commit_pc,
    input  logic [p_WORD_LEN-1:0] i_head_pc,
    output logic                  o_err_pc,
    output logic [15:0]           o_mismatch_cnt
);

    logic        r_err_pc;
    logic [15:0] r_mismatch_cnt;
    logic        w_mismatch;

    assign w_mismatch = i_check && (i_commit_pc != i_head_pc);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err_pc       <= 1'b0;
            r_mismatch_cnt <= '0;
        end else if (w_mismatch) begin
            r_err_pc <= 1'b1;
            if (r_mismatch_cnt != 16'hFFFF) begin
                r_mismatch_cnt <= r_mismatch_cnt + 16'd1;
            end
        end
    end

    assign o_err_pc       = r_err_pc;
    assign o_mismatch_cnt = r_mismatch_cnt;

endmodule

// File: rtl/inst_window.sv
// In-order instruction window: circular buffer with commit, squash and push applied in that order.
// Optional commit PC checking is built when INST_WINDOW_PC_CHECK_EN is defined.
module inst_window
    import inst_window_pkg::*;
#(
    parameter int p_WORD_LEN = 16,
    parameter int p_DEPTH    = 8,
    parameter int p_CNT_LEN  = $clog2(p_DEPTH) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic [p_WORD_LEN-1:0] i_push_inst,
    input  logic [p_WORD_LEN-1:0] i_push_pc,
    input  logic                  i_commit,
    input  logic [p_WORD_LEN-1:0] i_commit_pc,
    input  logic                  i_squash,
    input  logic [p_CNT_LEN-1:0]  i_squash_cnt,
    output logic                  o_head_valid,
    output logic [p_WORD_LEN-1:0] o_head_inst,
    output logic [p_WORD_LEN-1:0] o_head_pc,
    output logic [p_CNT_LEN-1:0]  o_count,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_err_ovf,
    output logic                  o_err_unf,
    output logic                  o_err_squash,
    output logic                  o_err_pc,
    output logic [15:0]           o_pc_mismatch_cnt
);

    localparam int c_PTR_LEN = $clog2(p_DEPTH);
    localparam logic [p_CNT_LEN-1:0] c_DEPTH_CNT = p_CNT_LEN'(p_DEPTH);

    // Same layout as entry_t, but sized by the instance's word length.
    typedef struct packed {
        logic [p_WORD_LEN-1:0] inst;
        logic [p_WORD_LEN-1:0] pc;
    } slot_t;

    slot_t                r_mem [p_DEPTH];
    logic [c_PTR_LEN-1:0] r_rd_ptr;
    logic [c_PTR_LEN-1:0] r_wr_ptr;
    logic [p_CNT_LEN-1:0] r_count;
    logic                 r_err_ovf;
    logic                 r_err_unf;
    logic                 r_err_squash;

    logic                 w_commit_ok;
    logic [p_CNT_LEN-1:0] w_cnt_commit;
    logic                 w_squash_over;
    logic [p_CNT_LEN-1:0] w_squash_k;
    logic [p_CNT_LEN-1:0] w_cnt_squash;
    logic                 w_push_ok;
    logic [c_PTR_LEN-1:0] w_wr_squash;
    slot_t                w_head;

    always_comb begin
        w_commit_ok   = i_commit && (r_count != '0);
        w_cnt_commit  = r_count - p_CNT_LEN'(w_commit_ok);
        w_squash_over = i_squash && (i_squash_cnt > w_cnt_commit);
        w_squash_k    = '0;
        if (i_squash) begin
            w_squash_k = w_squash_over ? w_cnt_commit : i_squash_cnt;
        end
        w_cnt_squash  = w_cnt_commit - w_squash_k;
        w_push_ok     = i_push && (w_cnt_squash < c_DEPTH_CNT);
        // Dropping all p_DEPTH entries leaves the pointer where it was, which the truncation gives.
        w_wr_squash   = r_wr_ptr - w_squash_k[c_PTR_LEN-1:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_err_ovf    <= 1'b0;
            r_err_unf    <= 1'b0;
            r_err_squash <= 1'b0;
        end else begin
            r_rd_ptr <= r_rd_ptr + c_PTR_LEN'(w_commit_ok);
            r_wr_ptr <= w_wr_squash + c_PTR_LEN'(w_push_ok);
            r_count  <= w_cnt_squash + p_CNT_LEN'(w_push_ok);
            if (i_push && !w_push_ok) begin
                r_err_ovf <= 1'b1;
            end
            if (i_commit && !w_commit_ok) begin
                r_err_unf <= 1'b1;
            end
            if (w_squash_over) begin
                r_err_squash <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && w_push_ok) begin
            r_mem[w_wr_squash] <= '{inst: i_push_inst, pc: i_push_pc};
        end
    end

    assign w_head       = r_mem[r_rd_ptr];
    assign o_head_valid = (r_count != '0);
    assign o_head_inst  = o_head_valid ? w_head.inst : '0;
    assign o_head_pc    = o_head_valid ? w_head.pc : '0;
    assign o_count      = r_count;
    assign o_full       = (r_count == c_DEPTH_CNT);
    assign o_empty      = (r_count == '0);
    assign o_err_ovf    = r_err_ovf;
    assign o_err_unf    = r_err_unf;
    assign o_err_squash = r_err_squash;

`ifdef INST_WINDOW_PC_CHECK_EN
    inst_window_chk #(
        .p_WORD_LEN (p_WORD_LEN)
    ) u_chk (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_check        (w_commit_ok),
        .i_commit_pc    (i_commit_pc),
        .i_head_pc      (o_head_pc),
        .o_err_pc       (o_err_pc),
        .o_mismatch_cnt (o_pc_mismatch_cnt)
    );
`else
    logic w_unused_commit_pc;
    assign w_unused_commit_pc = ^i_commit_pc;
    assign o_err_pc           = 1'b0;
    assign o_pc_mismatch_cnt  = '0;
`endif

endmodule

// File: tb/tb_inst_window.sv
// Directed bench for inst_window: vector table on an 8-deep window, hand sequences for reset,
// PC checking and wrap-around on a 4-deep window.
module tb_inst_window;
    import inst_window_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        push, commit, squash;
    logic [15:0] push_inst, push_pc, commit_pc;
    logic [3:0]  squash_cnt;
    logic        head_valid, full, empty, err_ovf, err_unf, err_sq, err_pc;
    logic [15:0] head_inst, head_pc, mm_cnt;
    logic [3:0]  count;

    logic        p4_push, p4_commit, p4_squash;
    logic [15:0] p4_push_inst, p4_push_pc, p4_commit_pc;
    logic [2:0]  p4_squash_cnt;
    logic        p4_head_valid, p4_full, p4_empty, p4_err_ovf, p4_err_unf, p4_err_sq, p4_err_pc;
    logic [15:0] p4_head_inst, p4_head_pc, p4_mm_cnt;
    logic [2:0]  p4_count;

    inst_window #(.p_WORD_LEN(16), .p_DEPTH(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_push(push), .i_push_inst(push_inst), .i_push_pc(push_pc),
        .i_commit(commit), .i_commit_pc(commit_pc), .i_squash(squash), .i_squash_cnt(squash_cnt),
        .o_head_valid(head_valid), .o_head_inst(head_inst), .o_head_pc(head_pc), .o_count(count),
        .o_full(full), .o_empty(empty), .o_err_ovf(err_ovf), .o_err_unf(err_unf),
        .o_err_squash(err_sq), .o_err_pc(err_pc), .o_pc_mismatch_cnt(mm_cnt)
    );

    inst_window #(.p_WORD_LEN(16), .p_DEPTH(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_push(p4_push), .i_push_inst(p4_push_inst),
        .i_push_pc(p4_push_pc), .i_commit(p4_commit), .i_commit_pc(p4_commit_pc),
        .i_squash(p4_squash), .i_squash_cnt(p4_squash_cnt), .o_head_valid(p4_head_valid),
        .o_head_inst(p4_head_inst), .o_head_pc(p4_head_pc), .o_count(p4_count), .o_full(p4_full),
        .o_empty(p4_empty), .o_err_ovf(p4_err_ovf), .o_err_unf(p4_err_unf),
        .o_err_squash(p4_err_sq), .o_err_pc(p4_err_pc), .o_pc_mismatch_cnt(p4_mm_cnt)
    );

    typedef struct {
        logic        push;
        logic [15:0] pc;
        logic        commit;
        logic [15:0] cpc;
        logic        squash;
        logic [3:0]  scnt;
        logic [3:0]  ecount;
        logic [15:0] ehpc;
        logic [2:0]  eerr;   // {squash, unf, ovf}, cumulative
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic logic [15:0] mkinst(input logic [15:0] pc);
        logic [2:0] op;
        case (pc[2:0])
            3'd0: op = ADD;
            3'd1: op = ADDI;
            3'd2: op = NAND;
            3'd3: op = LUI;
            3'd4: op = SW;
            3'd5: op = LW;
            3'd6: op = BEQ;
            default: op = JALR;
        endcase
        return {op, pc[12:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic p, input logic [15:0] pc, input logic c, input logic [15:0] cpc,
                       input logic s, input logic [3:0] scnt, input logic [3:0] ecount,
                       input logic [15:0] ehpc, input logic [2:0] eerr);
        vec_t v;
        v.push = p; v.pc = pc; v.commit = c; v.cpc = cpc; v.squash = s; v.scnt = scnt;
        v.ecount = ecount; v.ehpc = ehpc; v.eerr = eerr;
        vecs.push_back(v);
    endtask

    task automatic idle();
        push = 0; push_inst = 0; push_pc = 0; commit = 0; commit_pc = 0; squash = 0; squash_cnt = 0;
    endtask

    task automatic check_state(input string tag, input logic [3:0] ecount, input logic [15:0] ehpc,
                               input logic [2:0] eerr);
        logic ev;
        ev = (ecount != 0);
        check({tag, " count"}, 32'(count), 32'(ecount));
        check({tag, " head_valid"}, 32'(head_valid), 32'(ev));
        check({tag, " head_pc"}, 32'(head_pc), ev ? 32'(ehpc) : 32'd0);
        check({tag, " head_inst"}, 32'(head_inst), ev ? 32'(mkinst(ehpc)) : 32'd0);
        check({tag, " full"}, 32'(full), 32'(ecount == 4'd8));
        check({tag, " empty"}, 32'(empty), 32'(!ev));
        check({tag, " err_ovf"}, 32'(err_ovf), 32'(eerr[0]));
        check({tag, " err_unf"}, 32'(err_unf), 32'(eerr[1]));
        check({tag, " err_squash"}, 32'(err_sq), 32'(eerr[2]));
    endtask

    initial begin
        idle();
        p4_push = 0; p4_push_inst = 0; p4_push_pc = 0; p4_commit = 0; p4_commit_pc = 0;
        p4_squash = 0; p4_squash_cnt = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        check_state("reset", 4'd0, 16'h0, 3'b000);
        check("reset err_pc", 32'(err_pc), 32'd0);
        check("reset mm_cnt", 32'(mm_cnt), 32'd0);

        // basic push / commit
        add(1, 16'h0000, 0, 0, 0, 0, 4'd1, 16'h0000, 3'b000);
        add(1, 16'h0001, 0, 0, 0, 0, 4'd2, 16'h0000, 3'b000);
        add(1, 16'h0002, 0, 0, 0, 0, 4'd3, 16'h0000, 3'b000);
        add(0, 0, 1, 16'h0000, 0, 0, 4'd2, 16'h0001, 3'b000);
        add(0, 0, 1, 16'h0001, 0, 0, 4'd1, 16'h0002, 3'b000);
        add(0, 0, 1, 16'h0002, 0, 0, 4'd0, 16'h0000, 3'b000);
        // fill, overflow, push+commit while full, drain
        for (int i = 0; i < 8; i++) add(1, 16'h0030 + 16'(i), 0, 0, 0, 0, 4'(i + 1), 16'h0030, 3'b000);
        add(1, 16'h0038, 0, 0, 0, 0, 4'd8, 16'h0030, 3'b001);
        add(1, 16'h0039, 1, 16'h0030, 0, 0, 4'd8, 16'h0031, 3'b001);
        for (int i = 1; i < 7; i++) add(0, 0, 1, 16'h0030 + 16'(i), 0, 0, 4'(8 - i), 16'h0031 + 16'(i), 3'b001);
        add(0, 0, 1, 16'h0037, 0, 0, 4'd1, 16'h0039, 3'b001);
        add(0, 0, 1, 16'h0039, 0, 0, 4'd0, 16'h0000, 3'b001);
        // underflow
        add(0, 0, 1, 16'h0000, 0, 0, 4'd0, 16'h0000, 3'b011);
        // squash 2 + push redirect
        for (int i = 0; i < 5; i++) add(1, 16'h0010 + 16'(i), 0, 0, 0, 0, 4'(i + 1), 16'h0010, 3'b011);
        add(1, 16'h0020, 0, 0, 1, 4'd2, 4'd4, 16'h0010, 3'b011);
        add(0, 0, 1, 16'h0010, 0, 0, 4'd3, 16'h0011, 3'b011);
        add(0, 0, 1, 16'h0011, 0, 0, 4'd2, 16'h0012, 3'b011);
        add(0, 0, 1, 16'h0012, 0, 0, 4'd1, 16'h0020, 3'b011);
        add(0, 0, 1, 16'h0020, 0, 0, 4'd0, 16'h0000, 3'b011);
        // commit + over-sized squash
        add(1, 16'h0040, 0, 0, 0, 0, 4'd1, 16'h0040, 3'b011);
        add(1, 16'h0041, 0, 0, 0, 0, 4'd2, 16'h0040, 3'b011);
        add(0, 0, 1, 16'h0040, 1, 4'd3, 4'd0, 16'h0000, 3'b111);
        // zero-count squash is a no-op, exact squash raises nothing new
        add(1, 16'h0060, 0, 0, 0, 0, 4'd1, 16'h0060, 3'b111);
        add(0, 0, 0, 0, 1, 4'd0, 4'd1, 16'h0060, 3'b111);
        add(0, 0, 0, 0, 1, 4'd1, 4'd0, 16'h0000, 3'b111);

        foreach (vecs[i]) begin
            push = vecs[i].push; push_pc = vecs[i].pc; push_inst = mkinst(vecs[i].pc);
            commit = vecs[i].commit; commit_pc = vecs[i].cpc;
            squash = vecs[i].squash; squash_cnt = vecs[i].scnt;
            @(posedge clk);
            #1;
            idle();
            check_state($sformatf("vec%0d", i), vecs[i].ecount, vecs[i].ehpc, vecs[i].eerr);
            $display("vec %0d: push=%0b pc=%h commit=%0b squash=%0b/%0d -> count=%0d head=%h",
                     i, vecs[i].push, vecs[i].pc, vecs[i].commit, vecs[i].squash, vecs[i].scnt,
                     count, head_pc);
        end

        // reset mid-operation, with push and commit presented on the reset edge
        push = 1; push_pc = 16'h0050; push_inst = mkinst(16'h0050);
        @(posedge clk); #1;
        push_pc = 16'h0051; push_inst = mkinst(16'h0051);
        @(posedge clk); #1;
        check("pre-reset count", 32'(count), 32'd2);
        rst = 1; push_pc = 16'h0052; push_inst = mkinst(16'h0052); commit = 1; commit_pc = 16'h0050;
        @(posedge clk); #1;
        rst = 0; idle();
        check_state("midreset", 4'd0, 16'h0, 3'b000);
        $display("mid-op reset: count=%0d errs=%b%b%b", count, err_sq, err_unf, err_ovf);

        // commit PC mismatch
        push = 1; push_pc = 16'h0005; push_inst = mkinst(16'h0005);
        @(posedge clk); #1;
        idle();
        check_state("pc5", 4'd1, 16'h0005, 3'b000);
        commit = 1; commit_pc = 16'h0006;
        @(posedge clk); #1;
        idle();
        check("pcmm count", 32'(count), 32'd0);
`ifdef INST_WINDOW_PC_CHECK_EN
        check("pcmm err_pc", 32'(err_pc), 32'd1);
        check("pcmm mm_cnt", 32'(mm_cnt), 32'd1);
`else
        check("pcmm err_pc", 32'(err_pc), 32'd0);
        check("pcmm mm_cnt", 32'(mm_cnt), 32'd0);
`endif
        $display("pc mismatch: err_pc=%0b mm_cnt=%0d", err_pc, mm_cnt);

        // wrap-around on the 4-deep window: keep two entries in flight for 12 cycles
        for (int i = 0; i < 2; i++) begin
            p4_push = 1; p4_push_pc = 16'h0100 + 16'(i); p4_push_inst = mkinst(p4_push_pc);
            @(posedge clk); #1;
        end
        p4_push = 0;
        for (int i = 0; i < 12; i++) begin
            check($sformatf("wrap%0d head_pc", i), 32'(p4_head_pc), 32'h0100 + 32'(i));
            check($sformatf("wrap%0d head_inst", i), 32'(p4_head_inst), 32'(mkinst(16'h0100 + 16'(i))));
            check($sformatf("wrap%0d count", i), 32'(p4_count), 32'd2);
            $display("wrap %0d: head=%h count=%0d", i, p4_head_pc, p4_count);
            p4_push = 1; p4_push_pc = 16'h0102 + 16'(i); p4_push_inst = mkinst(p4_push_pc);
            p4_commit = 1; p4_commit_pc = 16'h0100 + 16'(i);
            @(posedge clk); #1;
        end
        p4_push = 0; p4_commit = 0;
        check("wrap final head", 32'(p4_head_pc), 32'h010C);
        check("wrap errs", 32'({p4_err_ovf, p4_err_unf, p4_err_sq, p4_err_pc}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
